ifetch_unit: RTL and testbench

- Instruction fetch sequencer directly downstream of the 16-bit program counter register.
- Takes the current PC value, runs a read handshake with instruction memory, and latches the returned word into an instruction register for the execution unit.
- Drives the PC register's pc_inc strobe.
- Handles branch flushes (PC loads driven by the execution unit), in-flight response discard, and memory timeout.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_timeout_ctr.sv | 29 ++
 rtl/ifetch_unit.sv | 153 +++++++++++++++
 tb/tb_ifetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and default bus widths.
package cpu_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUSY  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable down-counter with an expiry flag for bounding memory handshakes.
module fetch_timeout_ctr #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          expired
);

  assign expired = (count == {CW{1'b0}});

  // Load has priority; the count saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {CW{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (dec && !expired) begin
      count <= count - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: PC -> memory read handshake -> instruction register.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [AW-1:0] pc_in,
  output logic          pc_inc,
  input  logic          flush,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] ir_out,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ack,
  output logic          fetch_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT - 1);

  fetch_state_e state_r, next_state_s;
  logic load_addr_s, capture_s, clr_valid_s, set_err_s;
  logic ctr_load_s, ctr_dec_s, ctr_expired_s;
  logic [CW-1:0] ctr_count_s;

  fetch_timeout_ctr #(.CW(CW)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load_s),
    .load_val (TMO_LOAD),
    .dec      (ctr_dec_s),
    .count    (ctr_count_s),
    .expired  (ctr_expired_s)
  );

  // Strobes decode from the state register so they are low while reset holds IDLE
  assign mem_rd = (state_r == ST_BUSY);
  assign pc_inc = (state_r == ST_BUSY) & mem_rdy & ~flush;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    next_state_s = state_r;
    load_addr_s  = 1'b0;
    capture_s    = 1'b0;
    clr_valid_s  = 1'b0;
    set_err_s    = 1'b0;
    ctr_load_s   = 1'b0;
    ctr_dec_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run && !flush) begin
          load_addr_s  = 1'b1;
          ctr_load_s   = 1'b1;
          next_state_s = ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          next_state_s = mem_rdy ? ST_IDLE : ST_DRAIN;
        end else if (mem_rdy) begin
          capture_s    = 1'b1;
          next_state_s = ST_HOLD;
        end else if (ctr_expired_s) begin
          set_err_s    = 1'b1;
          next_state_s = ST_ERR;
        end else begin
          ctr_dec_s    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          clr_valid_s  = 1'b1;
          next_state_s = ST_IDLE;
        end else if (ir_ack) begin
          clr_valid_s = 1'b1;
          if (run) begin
            load_addr_s  = 1'b1;
            ctr_load_s   = 1'b1;
            next_state_s = ST_BUSY;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // The counter keeps its BUSY value so the whole request shares one budget
        if (mem_rdy) begin
          next_state_s = ST_IDLE;
        end else if (ctr_expired_s) begin
          set_err_s    = 1'b1;
          next_state_s = ST_ERR;
        end else begin
          ctr_dec_s    = 1'b1;
        end
      end
      ST_ERR: begin
        next_state_s = ST_ERR;
      end
      default: begin
        next_state_s = ST_ERR;
      end
    endcase
  end

  // Address, instruction register and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= {AW{1'b0}};
      ir_out    <= {DW{1'b0}};
      ir_pc     <= {AW{1'b0}};
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      if (load_addr_s) begin
        mem_addr <= pc_in;
      end
      if (capture_s) begin
        ir_out <= mem_data;
        ir_pc  <= mem_addr;
      end
      if (capture_s) begin
        ir_valid <= 1'b1;
      end else if (clr_valid_s) begin
        ir_valid <= 1'b0;
      end
      if (set_err_s) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a small PC register and memory responder.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, flush, ir_ack;
  logic [15:0] pc_in, mem_addr, mem_data, ir_out, ir_pc;
  logic        pc_inc, mem_rd, mem_rdy, ir_valid, fetch_err;

  logic        pc_set;
  logic [15:0] pc_drv, pc_reg, man_data;
  logic        man_rdy, auto_rdy;
  int          n_tests = 0;
  int          n_fail = 0;
  int          inc_cnt;

  ifetch_unit #(.DW(16), .AW(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run(run), .pc_in(pc_in), .pc_inc(pc_inc),
    .flush(flush), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdy(mem_rdy),
    .mem_data(mem_data), .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ack(ir_ack), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // PC register model: a flush is the execution unit loading a new PC
  always @(posedge clk) begin
    if (pc_set || flush) pc_reg <= pc_drv;
    else if (pc_inc)     pc_reg <= pc_reg + 16'd1;
  end
  assign pc_in    = pc_reg;
  assign mem_rdy  = auto_rdy ? mem_rd : man_rdy;
  assign mem_data = auto_rdy ? (16'h1000 ^ mem_addr) : man_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; flush = 1'b0; ir_ack = 1'b0;
    pc_set = 1'b1; pc_drv = 16'h0040; man_rdy = 1'b0; auto_rdy = 1'b0; man_data = 16'h0000;
    tick(); tick();
    check_val("rst_state", 32'(dut.state_r), 32'd0);
    check_val("rst_mem_rd", mem_rd, 1'b0);
    reset = 1'b0; pc_set = 1'b0;

    // Reset mid-BUSY
    run = 1'b1;
    tick();
    check_val("busy_addr40", mem_addr, 16'h0040);
    check_val("busy_rd", mem_rd, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_addr", mem_addr, 16'h0000);
    check_val("arst_rd", mem_rd, 1'b0);
    check_val("arst_state", 32'(dut.state_r), 32'd0);
    check_val("arst_err", fetch_err, 1'b0);
    check_val("arst_valid", ir_valid, 1'b0);
    check_val("arst_ir", ir_out, 16'h0000);
    check_val("arst_irpc", ir_pc, 16'h0000);
    check_val("arst_inc", pc_inc, 1'b0);
    run = 1'b0;
    tick();
    reset = 1'b0;

    // Single fetch at 0x0010
    pc_set = 1'b1; pc_drv = 16'h0010;
    tick();
    pc_set = 1'b0; run = 1'b1;
    tick();
    check_val("f1_addr", mem_addr, 16'h0010);
    check_val("f1_inc_lo", pc_inc, 1'b0);
    man_rdy = 1'b1; man_data = 16'hA5C3; run = 1'b0;
    #1;
    check_val("f1_inc_hi", pc_inc, 1'b1);
    tick();
    man_rdy = 1'b0;
    #1;
    check_val("f1_inc_once", pc_inc, 1'b0);
    check_val("f1_ir", ir_out, 16'hA5C3);
    check_val("f1_irpc", ir_pc, 16'h0010);
    check_val("f1_valid", ir_valid, 1'b1);
    check_val("f1_pc", pc_reg, 16'h0011);
    ir_ack = 1'b1;
    tick();
    check_val("f1_ack_valid", ir_valid, 1'b0);
    check_val("f1_idle", 32'(dut.state_r), 32'd0);
    tick();
    check_val("ack_idle_ign", 32'(dut.state_r), 32'd0);
    ir_ack = 1'b0;

    // Back-to-back, zero-wait memory, ack held high
    pc_set = 1'b1; pc_drv = 16'h0000;
    tick();
    pc_set = 1'b0; auto_rdy = 1'b1; ir_ack = 1'b1; run = 1'b1; inc_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (pc_inc) inc_cnt++;
      if ((k % 2) == 1) begin
        check_val("tp_addr", mem_addr, 32'((k - 1) / 2));
        check_val("tp_inc", pc_inc, 1'b1);
      end else begin
        check_val("tp_inc_gap", pc_inc, 1'b0);
        check_val("tp_valid", ir_valid, 1'b1);
        check_val("tp_irpc", ir_pc, 32'(k / 2 - 1));
        check_val("tp_ir", ir_out, 32'(16'h1000 ^ 16'(k / 2 - 1)));
      end
    end
    check_val("tp_inc_cnt", inc_cnt, 4);
    run = 1'b0;
    tick();
    check_val("tp_idle", 32'(dut.state_r), 32'd0);
    auto_rdy = 1'b0; ir_ack = 1'b0;

    // Flush in BUSY, response three cycles later
    pc_set = 1'b1; pc_drv = 16'h0100;
    tick();
    pc_set = 1'b0; run = 1'b1;
    tick();
    check_val("fl_addr", mem_addr, 16'h0100);
    flush = 1'b1; pc_drv = 16'h0200;
    #1;
    check_val("fl_inc", pc_inc, 1'b0);
    tick();
    flush = 1'b0;
    check_val("fl_drain", 32'(dut.state_r), 32'd3);
    check_val("fl_rd", mem_rd, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("fl_drain_flush", 32'(dut.state_r), 32'd3);
    man_rdy = 1'b1; man_data = 16'hDEAD;
    #1;
    check_val("fl_drain_inc", pc_inc, 1'b0);
    tick();
    man_rdy = 1'b0;
    check_val("fl_idle", 32'(dut.state_r), 32'd0);
    check_val("fl_valid", ir_valid, 1'b0);
    check_val("fl_err", fetch_err, 1'b0);
    tick();
    check_val("fl_new_addr", mem_addr, 16'h0200);
    man_rdy = 1'b1; man_data = 16'h1234;
    tick();
    man_rdy = 1'b0; run = 1'b0; ir_ack = 1'b1;
    check_val("fl_ir", ir_out, 16'h1234);
    tick();
    ir_ack = 1'b0;

    // Flush coincident with mem_rdy
    pc_set = 1'b1; pc_drv = 16'h0300;
    tick();
    pc_set = 1'b0; run = 1'b1;
    tick();
    flush = 1'b1; man_rdy = 1'b1; man_data = 16'hBEEF;
    #1;
    check_val("fr_inc", pc_inc, 1'b0);
    tick();
    flush = 1'b0; man_rdy = 1'b0; run = 1'b0;
    check_val("fr_idle", 32'(dut.state_r), 32'd0);
    check_val("fr_valid", ir_valid, 1'b0);
    check_val("fr_ir", ir_out, 16'h1234);

    // Timeout with TIMEOUT=4
    run = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) tick();
    check_val("to_busy4", 32'(dut.state_r), 32'd1);
    check_val("to_err_lo", fetch_err, 1'b0);
    tick();
    check_val("to_err_hi", fetch_err, 1'b1);
    check_val("to_rd", mem_rd, 1'b0);
    check_val("to_state", 32'(dut.state_r), 32'd4);
    man_rdy = 1'b1;
    tick(); tick();
    check_val("to_stay", 32'(dut.state_r), 32'd4);
    check_val("to_inc", pc_inc, 1'b0);
    man_rdy = 1'b0; run = 1'b0;
    reset = 1'b1;
    #1;
    check_val("to_rst_err", fetch_err, 1'b0);
    check_val("to_rst_state", 32'(dut.state_r), 32'd0);
    tick();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
